tmds_channel_decoder: RTL and testbench

//  Receive-side counterpart of the TMDS lane serializer: takes 10-bit raw words from a per-lane

---
 rtl/tmds_channel_decoder.sv | 219 +++++++++++++++++++++
 tb/tb_tmds_channel_decoder.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_channel_decoder.sv
// TMDS receive lane: finds the 10-bit symbol boundary in a raw deserialized word stream by
// hunting for runs of identical control tokens, then decodes each symbol to DE/C[1:0]/data.
module tmds_channel_decoder #(
    parameter int unsigned TOKEN_RUN     = 8,
    parameter int unsigned SEARCH_CYCLES = 1048576,
    parameter int unsigned VERIFY_RUNS   = 4,
    parameter int unsigned LOSS_TIMEOUT  = 1048576
) (
    input  logic       clk_pixel,
    input  logic       resetn,
    input  logic [9:0] in_word,
    output logic [7:0] out_data,
    output logic       out_de,
    output logic [1:0] out_ctrl,
    output logic       locked,
    output logic [3:0] bit_offset
);

    // run_cnt and vcount must be able to hold their terminal value itself
    localparam int unsigned RunW   = $clog2(TOKEN_RUN + 1);
    localparam int unsigned VcW    = $clog2(VERIFY_RUNS + 1);
    localparam int unsigned DwellW = (SEARCH_CYCLES > 1) ? $clog2(SEARCH_CYCLES) : 1;
    localparam int unsigned GapW   = (LOSS_TIMEOUT > 1) ? $clog2(LOSS_TIMEOUT) : 1;

    localparam logic [RunW-1:0]   RunMax    = RunW'(TOKEN_RUN);
    localparam logic [VcW-1:0]    VcTarget  = VcW'(VERIFY_RUNS);
    localparam logic [DwellW-1:0] DwellLast = DwellW'(SEARCH_CYCLES - 1);
    localparam logic [GapW-1:0]   GapLast   = GapW'(LOSS_TIMEOUT - 1);

    localparam logic [9:0] Tok00 = 10'b1101010100;
    localparam logic [9:0] Tok01 = 10'b0010101011;
    localparam logic [9:0] Tok10 = 10'b0101010100;
    localparam logic [9:0] Tok11 = 10'b1010101011;

    typedef enum logic [1:0] {StSearch, StVerify, StLocked} state_e;

    state_e            state_q, state_d;
    logic [9:0]        w0_q, w1_q;
    logic [9:0]        prev_sym_q;
    logic [3:0]        offset_q, offset_d, offset_inc;
    logic [RunW-1:0]   run_cnt_q, run_cnt_d;
    logic [DwellW-1:0] dwell_q, dwell_d;
    logic [GapW-1:0]   gap_q, gap_d;
    logic [VcW-1:0]    vcount_q, vcount_d;
    logic              run_hit, run_clr;
    logic              locked_q;
    logic              de_q;
    logic [1:0]        ctrl_q;
    logic [7:0]        data_q;

    // Bit 19 of the two-word window is never reachable with offsets 0..9
    logic [18:0] window;
    logic [9:0]  sym;
    logic        is_token;
    logic [1:0]  tok_code;
    logic [7:0]  dec_d, dec_q;

    assign window = {w0_q[8:0], w1_q};

    // Raw word pipeline: w1 holds the older word, w0 the newer
    always_ff @(posedge clk_pixel or negedge resetn) begin
        if (!resetn) begin
            w0_q <= '0;
            w1_q <= '0;
        end else begin
            w0_q <= in_word;
            w1_q <= w0_q;
        end
    end

    // Symbol extraction at the current bit offset
    always_comb begin
        sym = window[9:0];
        case (offset_q)
            4'd0:    sym = window[9:0];
            4'd1:    sym = window[10:1];
            4'd2:    sym = window[11:2];
            4'd3:    sym = window[12:3];
            4'd4:    sym = window[13:4];
            4'd5:    sym = window[14:5];
            4'd6:    sym = window[15:6];
            4'd7:    sym = window[16:7];
            4'd8:    sym = window[17:8];
            4'd9:    sym = window[18:9];
            default: sym = window[9:0];
        endcase
    end

    // Control token recognition and TMDS data decode
    always_comb begin
        is_token = 1'b1;
        tok_code = 2'b00;
        case (sym)
            Tok00:   tok_code = 2'b00;
            Tok01:   tok_code = 2'b01;
            Tok10:   tok_code = 2'b10;
            Tok11:   tok_code = 2'b11;
            default: is_token = 1'b0;
        endcase
        dec_d    = sym[9] ? ~sym[7:0] : sym[7:0];
        dec_q    = '0;
        dec_q[0] = dec_d[0];
        for (int i = 1; i < 8; i++) begin
            dec_q[i] = sym[8] ? (dec_d[i] ^ dec_d[i-1]) : ~(dec_d[i] ^ dec_d[i-1]);
        end
    end

    // Run length of identical tokens, saturating; hit only on the reaching cycle
    always_comb begin
        run_cnt_d = '0;
        if (is_token) begin
            if (sym == prev_sym_q) begin
                run_cnt_d = (run_cnt_q == RunMax) ? run_cnt_q : run_cnt_q + RunW'(1);
            end else begin
                run_cnt_d = RunW'(1);
            end
        end
        run_hit = (run_cnt_d == RunMax) && (run_cnt_q != RunMax);
    end

    // Run detector state; an offset change discards any partial run
    always_ff @(posedge clk_pixel or negedge resetn) begin
        if (!resetn) begin
            prev_sym_q <= '0;
            run_cnt_q  <= '0;
        end else begin
            prev_sym_q <= sym;
            run_cnt_q  <= run_clr ? '0 : run_cnt_d;
        end
    end

    assign offset_inc = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;

    // Alignment FSM next state: dwell per offset, verify, hold lock until runs stop
    always_comb begin
        state_d  = state_q;
        offset_d = offset_q;
        dwell_d  = dwell_q;
        gap_d    = gap_q;
        vcount_d = vcount_q;
        run_clr  = 1'b0;
        unique case (state_q)
            StSearch: begin
                if (run_hit) begin
                    state_d  = StVerify;
                    vcount_d = '0;
                    gap_d    = '0;
                    dwell_d  = '0;
                end else if (dwell_q == DwellLast) begin
                    offset_d = offset_inc;
                    dwell_d  = '0;
                    run_clr  = 1'b1;
                end else begin
                    dwell_d = dwell_q + DwellW'(1);
                end
            end
            StVerify, StLocked: begin
                if (run_hit) begin
                    gap_d = '0;
                    if (state_q == StVerify) begin
                        vcount_d = vcount_q + VcW'(1);
                        if (vcount_d == VcTarget) begin
                            state_d = StLocked;
                        end
                    end
                end else if (gap_q == GapLast) begin
                    state_d  = StSearch;
                    offset_d = offset_inc;
                    dwell_d  = '0;
                    gap_d    = '0;
                    vcount_d = '0;
                    run_clr  = 1'b1;
                end else begin
                    gap_d = gap_q + GapW'(1);
                end
            end
            default: state_d = StSearch;
        endcase
    end

    // Alignment FSM registers
    always_ff @(posedge clk_pixel or negedge resetn) begin
        if (!resetn) begin
            state_q  <= StSearch;
            offset_q <= '0;
            dwell_q  <= '0;
            gap_q    <= '0;
            vcount_q <= '0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            offset_q <= offset_d;
            dwell_q  <= dwell_d;
            gap_q    <= gap_d;
            vcount_q <= vcount_d;
            locked_q <= (state_d == StLocked);
        end
    end

    // Registered decode of the current symbol
    always_ff @(posedge clk_pixel or negedge resetn) begin
        if (!resetn) begin
            de_q   <= 1'b0;
            ctrl_q <= '0;
            data_q <= '0;
        end else begin
            de_q   <= ~is_token;
            ctrl_q <= is_token ? tok_code : 2'b00;
            data_q <= is_token ? 8'h00 : dec_q;
        end
    end

    assign locked     = locked_q;
    assign bit_offset = offset_q;
    assign out_de     = locked_q & de_q;
    assign out_ctrl   = locked_q ? ctrl_q : 2'b00;
    assign out_data   = locked_q ? data_q : 8'h00;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Directed bench for tmds_channel_decoder: lock acquisition, decode, tokens, reset, wrap.
module tb_tmds_channel_decoder;

    localparam int unsigned SearchCycles = 64;
    localparam int unsigned LossTimeout  = 200;
    localparam logic [9:0] T00 = 10'h354;
    localparam logic [9:0] T01 = 10'h0AB;
    localparam logic [9:0] T10 = 10'h154;
    localparam logic [9:0] T11 = 10'h2AB;
    localparam logic [9:0] D0  = 10'h100;

    logic       clk_pixel = 1'b0;
    logic       resetn;
    logic [9:0] in_word;
    logic [7:0] out_data;
    logic       out_de;
    logic [1:0] out_ctrl;
    logic       locked;
    logic [3:0] bit_offset;

    int         tests = 0;
    int         fails = 0;
    int         phase = 0;
    int         pat_pos = 0;
    logic [9:0] prev_sym = '0;

    tmds_channel_decoder #(
        .TOKEN_RUN    (8),
        .SEARCH_CYCLES(SearchCycles),
        .VERIFY_RUNS  (4),
        .LOSS_TIMEOUT (LossTimeout)
    ) dut (
        .clk_pixel (clk_pixel),
        .resetn    (resetn),
        .in_word   (in_word),
        .out_data  (out_data),
        .out_de    (out_de),
        .out_ctrl  (out_ctrl),
        .locked    (locked),
        .bit_offset(bit_offset)
    );

    always #5 clk_pixel = ~clk_pixel;

    // Serialize one symbol with 'phase' leading bits of skew, then wait one cycle
    task automatic step(input logic [9:0] s);
        logic [19:0] cat;
        cat      = {s, prev_sym} >> (10 - phase);
        in_word  = cat[9:0];
        prev_sym = s;
        @(negedge clk_pixel);
    endtask

    // Blanking pattern: 16 tokens then 16 data symbols
    task automatic pat_step();
        step(((pat_pos % 32) < 16) ? T00 : D0);
        pat_pos++;
    endtask

    task automatic do_reset();
        @(negedge clk_pixel);
        resetn   = 1'b0;
        in_word  = '0;
        prev_sym = '0;
        pat_pos  = 0;
        repeat (2) @(negedge clk_pixel);
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn  = 1'b0;
        in_word = '0;
        repeat (2) @(negedge clk_pixel);
        tests++;
        if ({out_de, out_ctrl, out_data, locked, bit_offset} !== 16'h0) begin
            fails++;
            $display("FAIL reset_state: got %h want 0000",
                     {out_de, out_ctrl, out_data, locked, bit_offset});
        end
    endtask

    task automatic test_lock();
        int cnt[10];
        int lock_step = -1;
        int prev_off = 0;
        bit bad_order = 0;
        for (int i = 0; i < 10; i++) cnt[i] = 0;
        phase = 3;
        do_reset();
        for (int s = 1; s <= 600 && lock_step < 0; s++) begin
            pat_step();
            if (bit_offset < 10) cnt[bit_offset]++;
            if (bit_offset != prev_off && bit_offset != prev_off + 1) bad_order = 1;
            prev_off = bit_offset;
            if (locked) lock_step = s;
        end
        tests++;
        if (lock_step !== 330) begin
            fails++;
            $display("FAIL lock_cycle: got %0d want 330", lock_step);
        end
        tests++;
        if (bit_offset !== 4'd3) begin
            fails++;
            $display("FAIL lock_offset: got %0d want 3", bit_offset);
        end
        tests++;
        if (cnt[0] !== 63 || cnt[1] !== 64 || cnt[2] !== 64 || bad_order) begin
            fails++;
            $display("FAIL lock_dwells: got %0d/%0d/%0d order_bad=%0d want 63/64/64 order_bad=0",
                     cnt[0], cnt[1], cnt[2], bad_order);
        end
    endtask

    task automatic test_decode();
        step(T00);
        step(T00);
        step(10'h100);
        step(10'h200);
        tests++;
        if ({locked, out_de, out_ctrl, out_data} !== 12'h800) begin
            fails++;
            $display("FAIL decode_latency: got %h want 800", {locked, out_de, out_ctrl, out_data});
        end
        step(T00);
        tests++;
        if ({out_de, out_ctrl, out_data} !== 11'h400) begin
            fails++;
            $display("FAIL decode_100: got %h want 400", {out_de, out_ctrl, out_data});
        end
        step(T00);
        tests++;
        if ({out_de, out_ctrl, out_data} !== 11'h4FF) begin
            fails++;
            $display("FAIL decode_200: got %h want 4ff", {out_de, out_ctrl, out_data});
        end
    endtask

    task automatic test_tokens();
        logic [9:0] seq [6];
        logic [1:0] exp_code [4];
        seq[0] = T00; seq[1] = T01; seq[2] = T10; seq[3] = T11; seq[4] = D0; seq[5] = D0;
        exp_code[0] = 2'b00; exp_code[1] = 2'b01; exp_code[2] = 2'b10; exp_code[3] = 2'b11;
        for (int i = 0; i < 6; i++) begin
            step(seq[i]);
            if (i >= 2) begin
                tests++;
                if ({out_de, out_ctrl, out_data} !== {1'b0, exp_code[i-2], 8'h00}) begin
                    fails++;
                    $display("FAIL token_%0d: got %h want %h", i - 2,
                             {out_de, out_ctrl, out_data}, {1'b0, exp_code[i-2], 8'h00});
                end
            end
        end
    endtask

    task automatic test_reset_locked();
        tests++;
        if (locked !== 1'b1) begin
            fails++;
            $display("FAIL pre_reset_locked: got %b want 1", locked);
        end
        resetn = 1'b0;
        #1;
        tests++;
        if ({out_de, out_ctrl, out_data, locked, bit_offset} !== 16'h0) begin
            fails++;
            $display("FAIL async_reset: got %h want 0000",
                     {out_de, out_ctrl, out_data, locked, bit_offset});
        end
        @(negedge clk_pixel);
        phase    = 0;
        prev_sym = '0;
        resetn   = 1'b1;
        repeat (63) step(D0);
        tests++;
        if ({locked, bit_offset} !== 5'h00) begin
            fails++;
            $display("FAIL post_reset_search: got %h want 00", {locked, bit_offset});
        end
        step(D0);
        tests++;
        if (bit_offset !== 4'd1) begin
            fails++;
            $display("FAIL post_reset_dwell: got %0d want 1", bit_offset);
        end
    endtask

    task automatic test_boundary();
        phase = 0;
        do_reset();
        for (int s = 1; s <= 130; s++) begin
            step((s >= 55 && s <= 62) ? T00 : D0);
            if (s == 64 || s == 130) begin
                tests++;
                if ({locked, bit_offset} !== 5'h00) begin
                    fails++;
                    $display("FAIL hit_on_expiry_s%0d: got %h want 00", s, {locked, bit_offset});
                end
            end
        end
        do_reset();
        for (int s = 1; s <= 64; s++) begin
            step((s >= 56 && s <= 62) ? T00 : D0);
        end
        tests++;
        if (bit_offset !== 4'd1) begin
            fails++;
            $display("FAIL run_of_7: got %0d want 1", bit_offset);
        end
    endtask

    task automatic test_wrap();
        int cnt[10];
        int lock_step = -1;
        int drop_step = -1;
        int relock_step = -1;
        int prev_off = 0;
        bit bad_order = 0;
        for (int i = 0; i < 10; i++) cnt[i] = 0;
        phase = 9;
        do_reset();
        for (int s = 1; s <= 1000 && lock_step < 0; s++) begin
            pat_step();
            if (bit_offset < 10) cnt[bit_offset]++;
            if (bit_offset != prev_off && bit_offset != prev_off + 1) bad_order = 1;
            prev_off = bit_offset;
            if (locked) lock_step = s;
        end
        tests++;
        if (lock_step !== 714 || bit_offset !== 4'd9) begin
            fails++;
            $display("FAIL wrap_lock: got step %0d offset %0d want step 714 offset 9",
                     lock_step, bit_offset);
        end
        for (int i = 1; i < 9; i++) begin
            tests++;
            if (cnt[i] !== 64 || bad_order) begin
                fails++;
                $display("FAIL wrap_dwell_%0d: got %0d order_bad=%0d want 64 order_bad=0",
                         i, cnt[i], bad_order);
            end
        end
        while (pat_pos % 32 != 16) pat_step();
        phase = 0;
        for (int s = 0; s < 400 && drop_step < 0; s++) begin
            pat_step();
            if (!locked) drop_step = pat_pos;
        end
        tests++;
        if (drop_step !== 914 || bit_offset !== 4'd0) begin
            fails++;
            $display("FAIL loss_timeout: got step %0d offset %0d want step 914 offset 0",
                     drop_step, bit_offset);
        end
        for (int s = 0; s < 600 && relock_step < 0; s++) begin
            pat_step();
            if (locked) relock_step = pat_pos;
        end
        tests++;
        if (relock_step !== 1066 || bit_offset !== 4'd0) begin
            fails++;
            $display("FAIL relock: got step %0d offset %0d want step 1066 offset 0",
                     relock_step, bit_offset);
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_decode();
        test_tokens();
        test_reset_locked();
        test_boundary();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
